// File: rtl/dmem_pkg.sv
// Shared defaults and FSM state type for the parametrised data memory.
// Imported by dmem_array and dmem_sync_param.
package dmem_pkg;

    localparam int DMEM_DATA_W_DEF = 10;
    localparam int DMEM_DEPTH_DEF  = 16;

    typedef enum logic {
        S_CLEAR,
        S_RUN
    } dmem_state_t;

endpackage

// File: rtl/dmem_array.sv
// Storage for the data memory: one synchronous write port, one async read port.
// Ports: clk, we/waddr/wdata (write), raddr/rdata (read, 0 when raddr >= DEPTH).
module dmem_array
    import dmem_pkg::*;
#(
    parameter  int WORD_W = DMEM_DATA_W_DEF,
    parameter  int DEPTH  = DMEM_DEPTH_DEF,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [WORD_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [WORD_W-1:0] rdata
);

    logic [WORD_W-1:0] mem_q [DEPTH];
    logic              raddr_ok;

    assign raddr_ok = ({1'b0, raddr} < (ADDR_W + 1)'(DEPTH));
    assign rdata    = raddr_ok ? mem_q[raddr] : '0;

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

endmodule

// File: rtl/dmem_sync_param.sv
// MEM-stage data memory: post-reset clear sequencer, registered write-first reads,
// out-of-range flagging. Optional even parity per word under DMEM_PARITY_EN.
// Ports: clk, rst (sync, active high), write_en, mem_read, address, write_data,
//        [parity_inject], read_data, read_valid, ready, addr_err, parity_err.
module dmem_sync_param
    import dmem_pkg::*;
#(
    parameter  int                DATA_W   = DMEM_DATA_W_DEF,
    parameter  int                DEPTH    = DMEM_DEPTH_DEF,
    parameter  logic [DATA_W-1:0] INIT_VAL = '0,
    localparam int                ADDR_W   = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              write_en,
    input  logic              mem_read,
    input  logic [ADDR_W-1:0] address,
    input  logic [DATA_W-1:0] write_data,
`ifdef DMEM_PARITY_EN
    input  logic              parity_inject,
`endif
    output logic [DATA_W-1:0] read_data,
    output logic              read_valid,
    output logic              ready,
    output logic              addr_err,
    output logic              parity_err
);

`ifdef DMEM_PARITY_EN
    localparam int WORD_W = DATA_W + 1;
`else
    localparam int WORD_W = DATA_W;
`endif

    dmem_state_t       state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic [DATA_W-1:0] read_data_q, read_data_d;
    logic              read_valid_q, read_valid_d;
    logic              addr_err_q, addr_err_d;
    logic              parity_err_q, parity_err_d;

    logic              addr_ok, rd_req, wr_req, wr_ok;
    logic              arr_we;
    logic [ADDR_W-1:0] arr_waddr;
    logic [WORD_W-1:0] arr_wdata, arr_rdata;
    logic [WORD_W-1:0] wr_word, init_word;
    logic [DATA_W-1:0] rd_data;
    logic              rd_par_bad;

    assign ready   = (state_q == S_RUN);
    assign addr_ok = ({1'b0, address} < (ADDR_W + 1)'(DEPTH));
    assign rd_req  = ready & mem_read;
    assign wr_req  = ready & write_en;
    assign wr_ok   = wr_req & addr_ok;

`ifdef DMEM_PARITY_EN
    // Stored word is {parity, data}; its XOR is 0 when intact.
    assign wr_word    = {(^write_data) ^ parity_inject, write_data};
    assign init_word  = {^INIT_VAL, INIT_VAL};
    assign rd_data    = arr_rdata[DATA_W-1:0];
    assign rd_par_bad = ^arr_rdata;
`else
    assign wr_word    = write_data;
    assign init_word  = INIT_VAL;
    assign rd_data    = arr_rdata;
    assign rd_par_bad = 1'b0;
`endif

    // FSM and array write-port steering
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        arr_we    = 1'b0;
        arr_waddr = address;
        arr_wdata = wr_word;
        unique case (state_q)
            S_CLEAR: begin
                arr_we    = 1'b1;
                arr_waddr = cnt_q;
                arr_wdata = init_word;
                cnt_d     = cnt_q + 1'b1;
                if (cnt_q == ADDR_W'(DEPTH - 1)) begin
                    state_d = S_RUN;
                    cnt_d   = '0;
                end
            end
            S_RUN: begin
                arr_we = wr_ok;
            end
        endcase
    end

    // Output registers. A single address port means a same-cycle
    // read and write always hit the same word, so bypass on wr_ok.
    always_comb begin
        read_data_d  = read_data_q;
        read_valid_d = rd_req;
        addr_err_d   = (rd_req | wr_req) & ~addr_ok;
        parity_err_d = 1'b0;
        if (rd_req) begin
            if (!addr_ok) begin
                read_data_d = '0;
            end else if (wr_ok) begin
                read_data_d = write_data;
            end else begin
                read_data_d  = rd_data;
                parity_err_d = rd_par_bad;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_CLEAR;
            cnt_q        <= '0;
            read_data_q  <= '0;
            read_valid_q <= 1'b0;
            addr_err_q   <= 1'b0;
            parity_err_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            read_data_q  <= read_data_d;
            read_valid_q <= read_valid_d;
            addr_err_q   <= addr_err_d;
            parity_err_q <= parity_err_d;
        end
    end

    assign read_data  = read_data_q;
    assign read_valid = read_valid_q;
    assign addr_err   = addr_err_q;
    assign parity_err = parity_err_q;

    dmem_array #(
        .WORD_W (WORD_W),
        .DEPTH  (DEPTH)
    ) u_array (
        .clk   (clk),
        .we    (arr_we),
        .waddr (arr_waddr),
        .wdata (arr_wdata),
        .raddr (address),
        .rdata (arr_rdata)
    );

endmodule

// File: tb/tb_dmem_sync_param.sv
// Directed bench for dmem_sync_param: DEPTH=16 and DEPTH=12 instances share stimulus.
// Parity cases run only when DMEM_PARITY_EN is defined.
module tb_dmem_sync_param;

    logic       clk = 1'b0;
    logic       rst;
    logic       write_en;
    logic       mem_read;
    logic [3:0] address;
    logic [9:0] write_data;
`ifdef DMEM_PARITY_EN
    logic       parity_inject;
`endif

    logic [9:0] rd16, rd12;
    logic       rv16, rv12, rdy16, rdy12, ae16, ae12, pe16, pe12;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    dmem_sync_param #(.DATA_W(10), .DEPTH(16), .INIT_VAL(10'd0)) u_d16 (
        .clk        (clk),
        .rst        (rst),
        .write_en   (write_en),
        .mem_read   (mem_read),
        .address    (address),
        .write_data (write_data),
`ifdef DMEM_PARITY_EN
        .parity_inject (parity_inject),
`endif
        .read_data  (rd16),
        .read_valid (rv16),
        .ready      (rdy16),
        .addr_err   (ae16),
        .parity_err (pe16)
    );

    dmem_sync_param #(.DATA_W(10), .DEPTH(12), .INIT_VAL(10'd0)) u_d12 (
        .clk        (clk),
        .rst        (rst),
        .write_en   (write_en),
        .mem_read   (mem_read),
        .address    (address),
        .write_data (write_data),
`ifdef DMEM_PARITY_EN
        .parity_inject (parity_inject),
`endif
        .read_data  (rd12),
        .read_valid (rv12),
        .ready      (rdy12),
        .addr_err   (ae12),
        .parity_err (pe12)
    );

    task automatic check(input string tag, input logic [31:0] act,
                         input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        write_en = 1'b0;
        mem_read = 1'b0;
    endtask

    initial begin
        int n;
        int r12;
        logic saw_rv;
        rst        = 1'b1;
        write_en   = 1'b0;
        mem_read   = 1'b0;
        address    = '0;
        write_data = '0;
`ifdef DMEM_PARITY_EN
        parity_inject = 1'b0;
`endif

        // reset state
        step();
        step();
        check("rst_ready", 32'(rdy16), 0);
        check("rst_rv", 32'(rv16), 0);
        check("rst_rd", 32'(rd16), 0);
        check("rst_ae", 32'(ae16), 0);
        check("rst_pe", 32'(pe16), 0);

        // clear latency
        rst = 1'b0;
        n   = 0;
        r12 = 0;
        while (!rdy16 && n < 40) begin
            step();
            n++;
            if (rdy12 && r12 == 0) r12 = n;
        end
        check("clr_lat16", 32'(n), 16);
        check("clr_lat12", 32'(r12), 12);

        // every address reads INIT_VAL
        for (int a = 0; a < 16; a++) begin
            mem_read = 1'b1;
            address  = 4'(a);
            step();
            check($sformatf("init_rv%0d", a), 32'(rv16), 1);
            check($sformatf("init_rd%0d", a), 32'(rd16), 0);
        end
        idle();
        step();
        check("idle_rv", 32'(rv16), 0);

        // write then back-to-back reads
        write_en   = 1'b1;
        address    = 4'd0;
        write_data = 10'b0010100101;
        step();
        check("wr_no_rv", 32'(rv16), 0);
        address    = 4'd1;
        write_data = 10'b0011100011;
        step();
        write_en = 1'b0;
        mem_read = 1'b1;
        address  = 4'd0;
        step();
        check("rd0_rv", 32'(rv16), 1);
        check("rd0", 32'(rd16), 32'h0A5);
        address = 4'd1;
        step();
        check("rd1", 32'(rd16), 32'h0E3);
        idle();
        step();
        check("hold_rd", 32'(rd16), 32'h0E3);
        check("hold_rv", 32'(rv16), 0);

        // write-first bypass
        write_en   = 1'b1;
        mem_read   = 1'b1;
        address    = 4'd5;
        write_data = 10'h3FF;
        step();
        check("byp_rd", 32'(rd16), 32'h3FF);
        check("byp_rv", 32'(rv16), 1);
        write_en = 1'b0;
        step();
        check("byp_rd2", 32'(rd16), 32'h3FF);

        // out-of-range on DEPTH=12
        idle();
        write_en   = 1'b1;
        address    = 4'd13;
        write_data = 10'h155;
        step();
        check("oor_wr_ae", 32'(ae12), 1);
        check("oor_wr_rv", 32'(rv12), 0);
        write_en = 1'b0;
        mem_read = 1'b1;
        step();
        check("oor_rd", 32'(rd12), 0);
        check("oor_rv", 32'(rv12), 1);
        check("oor_ae", 32'(ae12), 1);
        check("in16_rd", 32'(rd16), 32'h155);
        check("in16_ae", 32'(ae16), 0);
        address = 4'd1;
        step();
        check("alias_rd", 32'(rd12), 32'h0E3);
        check("alias_ae", 32'(ae12), 0);
        idle();

        // reset in the middle of a clear
        rst = 1'b1;
        step();
        check("rst2_rd", 32'(rd16), 0);
        check("rst2_rdy", 32'(rdy16), 0);
        rst = 1'b0;
        repeat (7) step();
        rst = 1'b1;
        step();
        rst        = 1'b0;
        write_en   = 1'b1;
        mem_read   = 1'b1;
        address    = 4'd2;
        write_data = 10'h3CC;
        n      = 0;
        saw_rv = 1'b0;
        while (!rdy16 && n < 40) begin
            step();
            n++;
            if (rv16) saw_rv = 1'b1;
        end
        check("reclr_lat", 32'(n), 16);
        check("reclr_norv", 32'(saw_rv), 0);
        write_en = 1'b0;
        step();
        check("reclr_rd2", 32'(rd16), 0);
        address = 4'd0;
        step();
        check("reclr_rd0", 32'(rd16), 0);
        idle();

`ifdef DMEM_PARITY_EN
        write_en      = 1'b1;
        parity_inject = 1'b1;
        address       = 4'd3;
        write_data    = 10'h0A5;
        step();
        write_en      = 1'b0;
        parity_inject = 1'b0;
        mem_read      = 1'b1;
        step();
        check("par_rd", 32'(rd16), 32'h0A5);
        check("par_err", 32'(pe16), 1);
        mem_read = 1'b0;
        write_en = 1'b1;
        step();
        write_en = 1'b0;
        mem_read = 1'b1;
        step();
        check("par_ok", 32'(pe16), 0);
        write_en      = 1'b1;
        parity_inject = 1'b1;
        step();
        check("par_byp", 32'(pe16), 0);
        parity_inject = 1'b0;
        idle();
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
